result_sram_fifo: RTL and testbench
===================================

Name: result_sram_fifo

Overview:
- Downstream result buffer for the coefficient dot-product stage. It captures each 32-bit accumulated result C as it is produced.
- Results are stored in a small synchronous SRAM-style array and presented in order to a consumer over a valid/ready interface with a registered output.
- Decouples the bursty dot-product producer from a slower reader (host readout or a writeback engine). Flags any result lost to a full buffer.

Parameters:
- DATA_W, 32, result word width (matches the dot-product output C).
- DEPTH, 16, total entries held (storage array plus output register); power of two, at least 2.
- ADDR_W, 4, log2(DEPTH); pointer width.

Ports:
- clk  input  1  single clock, all state on rising edge.
- rst  input  1  asynchronous, active-high reset.
- clear  input  1  synchronous flush: empties buffer, clears flags.
- wr_valid  input  1  producer has a result on wr_data.
- wr_ready  output  1  buffer can accept a result this cycle.
- wr_data  input  DATA_W  result word.
- rd_valid  output  1  rd_data holds the oldest unread result.
- rd_ready  input  1  consumer takes rd_data this cycle.
- rd_data  output  DATA_W  registered oldest result.
- count  output  ADDR_W+1  entries held, 0..DEPTH, including the output register.
- overflow  output  1  sticky: a write was offered while full.
- drop_cnt  output  8  saturating count of rejected writes.

Behaviour:
- Reset (async, rst=1):
  - wr_ptr=0, rd_ptr=0, count=0.
  - rd_valid=0, rd_data=0.
  - overflow=0, drop_cnt=0.
  - wr_ready=1 once rst deasserts.
  - Array contents are not reset.
- Write accept: wr_valid & wr_ready at a rising edge stores wr_data at mem[wr_ptr]; wr_ptr increments and wraps DEPTH-1 -> 0.
- wr_ready = (count < DEPTH). It is combinational from count only and never depends on rd_ready: no same-cycle pass-through when full.
- Pop: rd_valid & rd_ready at an edge.
- Output register load: if the array is non-empty and (rd_valid=0 or pop), then rd_data <= mem[rd_ptr], rd_ptr increments with wrap, and rd_valid <= 1.
- Output register drain: if pop and the array is empty, rd_valid <= 0 and rd_data holds its last value.
- Latency: a write accepted at edge N appears in the array after N. If the output register is empty, rd_valid=1 after edge N+1 with that word. Minimum write-to-read latency is 2 edges.
- Throughput: with continuous wr_valid and rd_ready, one word per cycle in steady state, order preserved.
- count: +1 on accepted write, -1 on pop, unchanged when both happen or neither. It never exceeds DEPTH and never underflows.
- Array occupancy = count - rd_valid.
- Full (count=DEPTH):
  - wr_ready=0.
  - wr_valid=1 sets overflow=1 and increments drop_cnt (saturates at 255).
  - The offered data is discarded.
- Empty (count=0): rd_valid=0; rd_ready is ignored.
- Simultaneous accepted write and pop while the array is empty and the output register is full: the written word goes to the array and loads into the output register on the next edge. count stays 1.
- clear=1 at an edge:
  - Behaves as a synchronous reset of pointers, count, rd_valid, overflow and drop_cnt.
  - A simultaneous write is dropped and is not counted as overflow.
  - A simultaneous pop is ignored.
  - clear has priority over all other events.
- Reset mid-operation: all queued results are lost immediately (async). Outputs return to reset values without waiting for clk.
- Data path is pure storage: no arithmetic on data, full DATA_W width preserved.

Test Plan:
- Reset, then write 0x00000024 with rd_ready=0 -> count=1 after edge 1, rd_valid=1 and rd_data=0x00000024 after edge 2.
- Write 16 words 0x1..0x10 back-to-back with rd_ready=0 -> wr_ready drops after the 16th accept, count=16. A 17th write of 0xDEAD sets overflow=1 and drop_cnt=1. A read-out then returns 0x1..0x10 in order, and 0xDEAD never appears.
- Continuous wr_valid and rd_ready for 40 words with incrementing data -> one word per cycle after the 2-cycle fill, order preserved across pointer wrap, count stays at or below 2.
- Fill to 16, then hold wr_valid=1 and rd_ready=1 in the same cycle -> pop occurs, write rejected (wr_ready=0), overflow=1, count=15.
- Load 5 words, then pulse clear together with wr_valid=1 -> count=0, rd_valid=0, overflow=0, drop_cnt=0. The next write reads back first.
- Assert rst asynchronously mid-stream between clock edges -> rd_valid, count and overflow go to 0 before the next edge. After release, a new write reads back as the first word.

Source files
------------

// File: rtl/result_sram_fifo.sv
// result_sram_fifo: in-order result buffer between the dot-product stage and a slower reader.
// Latency: a word written at edge N is in rd_data after edge N+1 if the output register was empty.
// Backpressure: wr_ready = (count < DEPTH) and ignores rd_ready; a write offered while full is dropped and counted.
// Ports:
//   clk, rst          clock, asynchronous active-high reset
//   clear             synchronous flush of pointers, count, rd_valid and flags
//   wr_valid/ready    producer handshake, wr_data is the result word
//   rd_valid/ready    consumer handshake, rd_data is the registered oldest word
//   count             entries held, including the output register
//   overflow          sticky flag: a write was offered while full
//   drop_cnt          saturating count of rejected writes
module result_sram_fifo #(
  parameter int DATA_W = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              wr_valid,
  output logic              wr_ready,
  input  logic [DATA_W-1:0] wr_data,
  output logic              rd_valid,
  input  logic              rd_ready,
  output logic [DATA_W-1:0] rd_data,
  output logic [ADDR_W:0]   count,
  output logic              overflow,
  output logic [7:0]        drop_cnt
);

  localparam logic [ADDR_W:0]   LP_FULL    = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W-1:0] LP_PTR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W:0]   LP_CNT_ONE = {{ADDR_W{1'b0}}, 1'b1};

  // Storage array: not reset, contents only meaningful between the pointers.
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_rd_valid;
  logic [DATA_W-1:0] r_rd_data;
  logic              r_overflow;
  logic [7:0]        r_drop_cnt;

  logic              w_wr_ready;
  logic              w_wr_acc;
  logic              w_pop;
  logic              w_drop;
  logic [ADDR_W:0]   w_arr_cnt;
  logic              w_arr_empty;
  logic              w_load;

  assign w_wr_ready  = (r_count < LP_FULL);
  assign w_wr_acc    = wr_valid & w_wr_ready & ~clear;
  assign w_pop       = r_rd_valid & rd_ready & ~clear;
  assign w_drop      = wr_valid & ~w_wr_ready & ~clear;
  // Words sitting in the array = total held minus the one in the output register.
  assign w_arr_cnt   = r_count - {{ADDR_W{1'b0}}, r_rd_valid};
  assign w_arr_empty = (w_arr_cnt == '0);
  // Refill the output register whenever it is empty or being popped. A word written
  // this same edge is not yet visible in the array, so it loads one edge later.
  assign w_load      = ~w_arr_empty & (~r_rd_valid | w_pop);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_rd_data  <= '0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else if (clear) begin
      // rd_data is left holding its last value; rd_valid=0 marks it stale.
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_rd_valid <= 1'b0;
      r_overflow <= 1'b0;
      r_drop_cnt <= '0;
    end else begin
      if (w_wr_acc) begin
        r_wr_ptr <= r_wr_ptr + LP_PTR_ONE;
      end
      if (w_load) begin
        r_rd_data  <= r_mem[r_rd_ptr];
        r_rd_ptr   <= r_rd_ptr + LP_PTR_ONE;
        r_rd_valid <= 1'b1;
      end else if (w_pop) begin
        r_rd_valid <= 1'b0;
      end
      case ({w_wr_acc, w_pop})
        2'b10:   r_count <= r_count + LP_CNT_ONE;
        2'b01:   r_count <= r_count - LP_CNT_ONE;
        default: r_count <= r_count;
      endcase
      if (w_drop) begin
        r_overflow <= 1'b1;
        if (r_drop_cnt != 8'hFF) begin
          r_drop_cnt <= r_drop_cnt + 8'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr_acc) begin
      r_mem[r_wr_ptr] <= wr_data;
    end
  end

  assign wr_ready = w_wr_ready;
  assign rd_valid = r_rd_valid;
  assign rd_data  = r_rd_data;
  assign count    = r_count;
  assign overflow = r_overflow;
  assign drop_cnt = r_drop_cnt;

endmodule

// File: tb/tb_result_sram_fifo.sv
// tb_result_sram_fifo: directed and randomized checks of result_sram_fifo against a queue model.
// The model keeps the accepted words in order, the sticky overflow flag and the saturating drop count.
module tb_result_sram_fifo;

  localparam int DEPTH = 16;

  logic        clk = 1'b0;
  logic        rst;
  logic        clear;
  logic        wr_valid;
  logic        wr_ready;
  logic [31:0] wr_data;
  logic        rd_valid;
  logic        rd_ready;
  logic [31:0] rd_data;
  logic [4:0]  count;
  logic        overflow;
  logic [7:0]  drop_cnt;

  result_sram_fifo #(.DATA_W(32), .DEPTH(DEPTH), .ADDR_W(4)) dut (
    .clk(clk), .rst(rst), .clear(clear),
    .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_data(wr_data),
    .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_data(rd_data),
    .count(count), .overflow(overflow), .drop_cnt(drop_cnt)
  );

  always #5 clk = ~clk;

  int          n_cmp  = 0;
  int          n_fail = 0;
  int          n_pops = 0;
  logic [31:0] mq[$];
  logic        m_ovf  = 1'b0;
  int          m_drop = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    mq.delete();
    m_ovf  = 1'b0;
    m_drop = 0;
  endtask

  // One clock cycle: drive after the falling edge, check handshake-side values
  // before the rising edge, update the model and check state after it.
  task automatic cyc(input logic wv, input logic [31:0] wd, input logic rr, input logic clr);
    logic do_push;
    logic do_pop;
    logic do_drop;
    @(negedge clk);
    wr_valid = wv;
    wr_data  = wd;
    rd_ready = rr;
    clear    = clr;
    #1;
    chk("wr_ready", {31'b0, wr_ready}, {31'b0, (mq.size() < DEPTH)});
    do_push = wv && (mq.size() < DEPTH) && !clr;
    do_drop = wv && (mq.size() >= DEPTH) && !clr;
    do_pop  = 1'b0;
    if (rd_valid === 1'b1 && rr && !clr) begin
      if (mq.size() == 0) begin
        chk("rd_valid_on_empty", {31'b0, rd_valid}, 32'd0);
      end else begin
        chk("rd_data", rd_data, mq[0]);
        do_pop = 1'b1;
      end
    end
    @(posedge clk);
    #1;
    if (clr) begin
      model_reset();
    end else begin
      if (do_pop) begin
        void'(mq.pop_front());
        n_pops++;
      end
      if (do_push) mq.push_back(wd);
      if (do_drop) begin
        m_ovf = 1'b1;
        if (m_drop < 255) m_drop++;
      end
    end
    chk("count", {27'b0, count}, 32'(mq.size()));
    chk("overflow", {31'b0, overflow}, {31'b0, m_ovf});
    chk("drop_cnt", {24'b0, drop_cnt}, 32'(m_drop));
    if (mq.size() >= 2) chk("rd_valid_busy", {31'b0, rd_valid}, 32'd1);
    if (mq.size() == 0) chk("rd_valid_idle", {31'b0, rd_valid}, 32'd0);
  endtask

  initial begin
    int p0;
    rst      = 1'b1;
    clear    = 1'b0;
    wr_valid = 1'b0;
    wr_data  = '0;
    rd_ready = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_count", {27'b0, count}, 32'd0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_rd_data", rd_data, 32'd0);
    chk("rst_overflow", {31'b0, overflow}, 32'd0);
    chk("rst_drop_cnt", {24'b0, drop_cnt}, 32'd0);
    rst = 1'b0;
    #1;
    chk("rst_wr_ready", {31'b0, wr_ready}, 32'd1);

    // First write: count after one edge, output register after two.
    cyc(1'b1, 32'h0000_0024, 1'b0, 1'b0);
    chk("lat_rd_valid_e1", {31'b0, rd_valid}, 32'd0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("lat_rd_valid_e2", {31'b0, rd_valid}, 32'd1);
    chk("lat_rd_data_e2", rd_data, 32'h0000_0024);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Fill to full, offer one extra, then read everything back in order.
    for (int i = 1; i <= 16; i++) cyc(1'b1, 32'(i), 1'b0, 1'b0);
    chk("full_count", {27'b0, count}, 32'd16);
    chk("full_wr_ready", {31'b0, wr_ready}, 32'd0);
    cyc(1'b1, 32'h0000_DEAD, 1'b0, 1'b0);
    chk("full_overflow", {31'b0, overflow}, 32'd1);
    chk("full_drop_cnt", {24'b0, drop_cnt}, 32'd1);
    for (int i = 0; i < 17; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Streaming: one pop per cycle after the two-cycle fill, count <= 2.
    p0 = n_pops;
    for (int i = 0; i < 40; i++) begin
      cyc(1'b1, 32'h1000 + 32'(i), 1'b1, 1'b0);
      chk("stream_count_le2", {31'b0, (count <= 5'd2)}, 32'd1);
    end
    chk("stream_pops", 32'(n_pops - p0), 32'd38);
    for (int i = 0; i < 3; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Full with simultaneous write and pop: pop happens, write is rejected.
    for (int i = 0; i < 16; i++) cyc(1'b1, 32'h2000 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_BEEF, 1'b1, 1'b0);
    chk("fullrw_count", {27'b0, count}, 32'd15);
    chk("fullrw_overflow", {31'b0, overflow}, 32'd1);
    for (int i = 0; i < 16; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // clear with a simultaneous write: everything zeroed, next write reads first.
    for (int i = 0; i < 5; i++) cyc(1'b1, 32'h3000 + 32'(i), 1'b0, 1'b0);
    cyc(1'b1, 32'h0000_3FFF, 1'b1, 1'b1);
    chk("clr_count", {27'b0, count}, 32'd0);
    chk("clr_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("clr_overflow", {31'b0, overflow}, 32'd0);
    chk("clr_drop_cnt", {24'b0, drop_cnt}, 32'd0);
    cyc(1'b1, 32'h0000_5A5A, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("clr_first_word", rd_data, 32'h0000_5A5A);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Asynchronous reset between edges while full and overflowed.
    for (int i = 0; i < 17; i++) cyc(1'b1, 32'h4000 + 32'(i), 1'b0, 1'b0);
    @(negedge clk);
    wr_valid = 1'b0;
    #2;
    rst = 1'b1;
    #1;
    chk("arst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("arst_count", {27'b0, count}, 32'd0);
    chk("arst_overflow", {31'b0, overflow}, 32'd0);
    chk("arst_rd_data", rd_data, 32'd0);
    model_reset();
    @(negedge clk);
    rst = 1'b0;
    cyc(1'b1, 32'h0000_0077, 1'b0, 1'b0);
    cyc(1'b0, 32'h0, 1'b0, 1'b0);
    chk("arst_first_word", rd_data, 32'h0000_0077);
    cyc(1'b0, 32'h0, 1'b1, 1'b0);

    // Randomized traffic: slow reader phase (fills/overflows), then fast reader.
    for (int i = 0; i < 400; i++) begin
      logic wv;
      logic rr;
      logic cl;
      wv = ($urandom_range(0, 3) != 0);
      rr = (i < 200) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0);
      cl = ($urandom_range(0, 79) == 0);
      cyc(wv, $urandom, rr, cl);
    end
    for (int i = 0; i < 20; i++) cyc(1'b0, 32'h0, 1'b1, 1'b0);
    chk("final_count", {27'b0, count}, 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
